// File: rtl/peripheral_apb4_memory_pkg.sv
// Shared types and constants for the APB4 scratch memory: FSM states,
// wait-counter width and the byte-address to word-index shift.
package peripheral_apb4_memory_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  localparam int CNT_W = 4;

  function automatic int idx_shift(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/peripheral_apb4_memory_ram.sv
// DEPTH x DATA_WIDTH flop array with per-byte-lane write enables,
// an asynchronous read port and an asynchronous clear.
module peripheral_apb4_memory_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int IDX_W      = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [IDX_W-1:0]        i_widx,
  input  logic [DATA_WIDTH/8-1:0] i_we,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [IDX_W-1:0]        i_ridx,
  output logic [DATA_WIDTH-1:0]   o_rdata
);

  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int w = 0; w < DEPTH; w++) r_mem[w] <= '0;
    end else begin
      for (int w = 0; w < DEPTH; w++) begin
        for (int b = 0; b < NB; b++) begin
          if (i_we[b] && (i_widx == IDX_W'(w)))
            r_mem[w][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Non-power-of-two depths leave index codes with no backing word.
  assign o_rdata = (32'(i_ridx) < DEPTH) ? r_mem[i_ridx] : '0;

endmodule

// File: rtl/peripheral_apb4_memory.sv
// APB4 slave scratch memory: setup/access FSM, wait-state counter,
// out-of-range detection and fully registered prdata/pready/pslverr.
module peripheral_apb4_memory
  import peripheral_apb4_memory_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic                    pwrite,
  input  logic                    psel,
  input  logic                    penable,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int SHIFT = idx_shift(DATA_WIDTH);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT_STATES);

  apb_state_e            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_write;
  logic                  r_oor;
  logic [IDX_W-1:0]      r_idx;
  logic [NB-1:0]         r_strb;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_prdata;
  logic                  r_pready;
  logic                  r_pslverr;

  logic [ADDR_WIDTH-1:0] w_idx_full;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_oor;
  logic                  w_setup;
  logic                  w_commit;
  logic [NB-1:0]         w_we;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_idx_full = paddr >> SHIFT;
  assign w_idx      = w_idx_full[IDX_W-1:0];
  assign w_oor      = (w_idx_full >= ADDR_WIDTH'(DEPTH));
  assign w_setup    = (r_state == IDLE) && psel && !penable;
  assign w_commit   = (r_state == ACCESS) && psel && penable && r_pready;
  assign w_we       = (w_commit && r_write && !r_oor) ? r_strb : '0;

  peripheral_apb4_memory_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_ram (
    .i_clk   (pclk),
    .i_rst_n (presetn),
    .i_widx  (r_idx),
    .i_we    (w_we),
    .i_wdata (r_wdata),
    .i_ridx  (w_idx),
    .o_rdata (w_rdata)
  );

  // Transfer attributes are data-only; their value outside a transfer is irrelevant.
  always_ff @(posedge pclk) begin
    if (w_setup) begin
      r_idx   <= w_idx;
      r_strb  <= pstrb;
      r_wdata <= pwdata;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_write   <= 1'b0;
      r_oor     <= 1'b0;
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_setup) begin
            r_state   <= ACCESS;
            r_cnt     <= WAIT_CNT;
            r_write   <= pwrite;
            r_oor     <= w_oor;
            r_prdata  <= (!pwrite && !w_oor) ? w_rdata : '0;
            r_pready  <= (WAIT_CNT == '0);
            r_pslverr <= w_oor && (WAIT_CNT == '0);
          end
        end
        ACCESS: begin
          // Completion and abort both return to IDLE with outputs cleared.
          if (!psel || (penable && r_pready)) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_prdata  <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
              r_pready  <= 1'b1;
              r_pslverr <= r_oor;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign prdata  = r_prdata;
  assign pready  = r_pready;
  assign pslverr = r_pslverr;

endmodule

// File: tb/tb_peripheral_apb4_memory.sv
// Bench for peripheral_apb4_memory: two instances (0 and 3 wait states)
// checked against a word-array reference model and a table of vectors.
module tb_peripheral_apb4_memory;

  localparam int WS0 = 0;
  localparam int WS1 = 3;

  logic        pclk = 1'b0;
  logic        presetn;
  logic [15:0] paddr;
  logic [3:0]  pstrb;
  logic        pwrite;
  logic        psel0, psel1;
  logic        penable;
  logic [31:0] pwdata;
  logic [31:0] prdata0, prdata1;
  logic        pready0, pready1;
  logic        pslverr0, pslverr1;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem_m [2][256];

  always #5 pclk = ~pclk;

  peripheral_apb4_memory #(
    .ADDR_WIDTH(16), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(WS0)
  ) dut0 (
    .pclk(pclk), .presetn(presetn), .paddr(paddr), .pstrb(pstrb),
    .pwrite(pwrite), .psel(psel0), .penable(penable), .pwdata(pwdata),
    .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
  );

  peripheral_apb4_memory #(
    .ADDR_WIDTH(16), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(WS1)
  ) dut1 (
    .pclk(pclk), .presetn(presetn), .paddr(paddr), .pstrb(pstrb),
    .pwrite(pwrite), .psel(psel1), .penable(penable), .pwdata(pwdata),
    .prdata(prdata1), .pready(pready1), .pslverr(pslverr1)
  );

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl [14];

  function automatic logic rdy(input int d);
    return (d == 0) ? pready0 : pready1;
  endfunction

  function automatic logic serr(input int d);
    return (d == 0) ? pslverr0 : pslverr1;
  endfunction

  function automatic logic [31:0] rdat(input int d);
    return (d == 0) ? prdata0 : prdata1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 256; w++) mem_m[d][w] = '0;
  endtask

  task automatic model_xfer(input int d, input logic wr, input logic [15:0] addr,
                            input logic [3:0] strb, input logic [31:0] wd,
                            output logic [31:0] rd, output logic err);
    int idx;
    idx = int'(addr) / 4;
    rd  = '0;
    err = (idx >= 256);
    if (!err) begin
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (strb[b]) mem_m[d][idx][b*8 +: 8] = wd[b*8 +: 8];
      end else begin
        rd = mem_m[d][idx];
      end
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the completion edge.
  task automatic xfer(input int d, input logic wr, input logic [15:0] addr,
                      input logic [3:0] strb, input logic [31:0] wd,
                      output logic [31:0] rd, output logic err);
    int  nw;
    logic ok;
    if (d == 0) psel0 = 1'b1; else psel1 = 1'b1;
    penable = 1'b0; pwrite = wr; paddr = addr; pstrb = strb; pwdata = wd;
    chk("setup_pready_low", rdy(d), 1'b0);
    @(posedge pclk); #1;
    penable = 1'b1;
    nw = 0; ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (rdy(d)) ok = 1'b1;
      else begin
        chk("wait_pslverr_low", serr(d), 1'b0);
        nw++;
        @(posedge pclk); #1;
      end
    end
    rd  = rdat(d);
    err = serr(d);
    if (!ok) begin
      checks++; errors++;
      $display("FAIL pready_timeout: actual=never required=ready dut=%0d", d);
    end
    chk("wait_cycles", nw, (d == 0) ? WS0 : WS1);
    @(posedge pclk); #1;
    psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
    chk("done_pready_low", rdy(d), 1'b0);
    chk("done_pslverr_low", serr(d), 1'b0);
    chk("done_prdata_zero", rdat(d), 32'h0);
  endtask

  task automatic run(input int d, input logic wr, input logic [15:0] addr,
                     input logic [3:0] strb, input logic [31:0] wd);
    logic [31:0] rd, erd;
    logic err, eerr;
    model_xfer(d, wr, addr, strb, wd, erd, eerr);
    xfer(d, wr, addr, strb, wd, rd, err);
    chk("rand_pslverr", err, eerr);
    if (!wr) chk("rand_prdata", rd, erd);
  endtask

  initial begin
    logic [31:0] rd, erd;
    logic err, eerr;
    int d, pick, idx;

    tbl[0]  = '{1'b0, 16'h0000, 4'b0000, 32'h0,        32'h00000000, 1'b0};
    tbl[1]  = '{1'b1, 16'h0010, 4'b1111, 32'hDEADBEEF, 32'h0,        1'b0};
    tbl[2]  = '{1'b0, 16'h0010, 4'b0000, 32'h0,        32'hDEADBEEF, 1'b0};
    tbl[3]  = '{1'b1, 16'h0020, 4'b1111, 32'hAAAAAAAA, 32'h0,        1'b0};
    tbl[4]  = '{1'b1, 16'h0020, 4'b0101, 32'h11223344, 32'h0,        1'b0};
    tbl[5]  = '{1'b0, 16'h0020, 4'b0000, 32'h0,        32'hAA22AA44, 1'b0};
    tbl[6]  = '{1'b1, 16'h0400, 4'b1111, 32'h55555555, 32'h0,        1'b1};
    tbl[7]  = '{1'b0, 16'h0000, 4'b0000, 32'h0,        32'h00000000, 1'b0};
    tbl[8]  = '{1'b0, 16'h0400, 4'b0000, 32'h0,        32'h00000000, 1'b1};
    tbl[9]  = '{1'b1, 16'h0013, 4'b0001, 32'h00000055, 32'h0,        1'b0};
    tbl[10] = '{1'b0, 16'h0012, 4'b0000, 32'h0,        32'hDEADBE55, 1'b0};
    tbl[11] = '{1'b1, 16'h0010, 4'b0000, 32'hFFFFFFFF, 32'h0,        1'b0};
    tbl[12] = '{1'b0, 16'h0010, 4'b0000, 32'h0,        32'hDEADBE55, 1'b0};
    tbl[13] = '{1'b0, 16'h03FC, 4'b0000, 32'h0,        32'h00000000, 1'b0};

    model_clear();
    presetn = 1'b0; psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
    pwrite = 1'b0; paddr = '0; pstrb = '0; pwdata = '0;
    repeat (3) @(posedge pclk);
    #1;
    chk("reset_prdata0", prdata0, 32'h0);
    chk("reset_pready0", pready0, 1'b0);
    chk("reset_pslverr0", pslverr0, 1'b0);
    chk("reset_prdata1", prdata1, 32'h0);
    chk("reset_pready1", pready1, 1'b0);
    chk("reset_pslverr1", pslverr1, 1'b0);
    presetn = 1'b1;
    @(posedge pclk); #1;

    for (int i = 0; i < 14; i++) begin
      model_xfer(0, tbl[i].wr, tbl[i].addr, tbl[i].strb, tbl[i].wdata, erd, eerr);
      xfer(0, tbl[i].wr, tbl[i].addr, tbl[i].strb, tbl[i].wdata, rd, err);
      chk($sformatf("vec%0d_pslverr", i), err, tbl[i].exp_err);
      if (!tbl[i].wr) chk($sformatf("vec%0d_prdata", i), rd, tbl[i].exp_rd);
    end

    // Three-wait-state instance: write then read back.
    run(1, 1'b1, 16'h0010, 4'b1111, 32'hDEADBEEF);
    run(1, 1'b0, 16'h0010, 4'b0000, 32'h0);
    run(1, 1'b1, 16'h0400, 4'b1111, 32'h12345678);
    run(1, 1'b0, 16'h0400, 4'b0000, 32'h0);

    for (int i = 0; i < 60; i++) begin
      d    = $urandom_range(0, 1);
      pick = $urandom_range(0, 9);
      idx  = (pick < 8) ? pick : (pick == 8) ? 255 : $urandom_range(256, 400);
      run(d, 1'($urandom_range(0, 1)), 16'(idx * 4 + $urandom_range(0, 3)),
          4'($urandom_range(0, 15)), $urandom);
    end

    // Abort: psel dropped during a write's wait states.
    psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0008;
    pstrb = 4'hF; pwdata = 32'hCAFEF00D;
    @(posedge pclk); #1;
    penable = 1'b1;
    chk("abort_wait_pready", pready1, 1'b0);
    @(posedge pclk); #1;
    psel1 = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    chk("abort_idle_pready", pready1, 1'b0);
    chk("abort_idle_pslverr", pslverr1, 1'b0);
    run(1, 1'b0, 16'h0008, 4'b0000, 32'h0);

    // Reset asserted during the completion cycle of a write.
    run(0, 1'b1, 16'h0040, 4'b1111, 32'h0BADF00D);
    psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0010;
    pstrb = 4'hF; pwdata = 32'h12345678;
    @(posedge pclk); #1;
    penable = 1'b1;
    chk("rst_pre_pready", pready0, 1'b1);
    #2 presetn = 1'b0;
    #1;
    chk("rst_mid_pready", pready0, 1'b0);
    chk("rst_mid_pslverr", pslverr0, 1'b0);
    chk("rst_mid_prdata", prdata0, 32'h0);
    psel0 = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    presetn = 1'b1;
    model_clear();
    @(posedge pclk); #1;
    run(0, 1'b0, 16'h0010, 4'b0000, 32'h0);
    run(0, 1'b0, 16'h0040, 4'b0000, 32'h0);
    run(1, 1'b0, 16'h0010, 4'b0000, 32'h0);
    run(0, 1'b1, 16'h0044, 4'b1001, 32'hA1B2C3D4);
    run(0, 1'b0, 16'h0044, 4'b0000, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/peripheral_apb4_memory.md
# peripheral_apb4_memory

Parametrised APB4 slave memory with byte-strobe writes, configurable wait states and out-of-range error reporting. It is the next-generation on-chip scratch memory for the peripheral subsystem. It sits behind the APB4 bridge as a verification and application target. Unlike the previous 8-bit/256-entry block, data width, depth and latency are parametrised, and `pready`/`pslverr` carry real protocol information.

## Interface
- `ADDR_WIDTH`, 16: width of `paddr` (byte address).
- `DATA_WIDTH`, 32: data bus width; must be 8, 16, 32 or 64.
- `DEPTH`, 256: number of `DATA_WIDTH` words; need not be a power of two.
- `WAIT_STATES`, 0: access-phase cycles with `pready` low before completion (0..15).
- `pclk`  in  1  clock; all logic rises on posedge.
- `presetn`  in  1  reset; one clock, asynchronous, active-low.
- `paddr`  in  ADDR_WIDTH  byte address.
- `pstrb`  in  DATA_WIDTH/8  write byte-lane strobes.
- `pwrite`  in  1  1 = write, 0 = read.
- `psel`  in  1  slave select.
- `penable`  in  1  access phase.
- `pwdata`  in  DATA_WIDTH  write data.
- `prdata`  out  DATA_WIDTH  read data.
- `pready`  out  1  transfer completion.
- `pslverr`  out  1  transfer error.

## Operation
- Word index: `paddr >> log2(DATA_WIDTH/8)`. Low address bits are ignored.
- An index of DEPTH or above is out of range.
- FSM states:
  - IDLE → ACCESS on `psel && !penable` (setup phase).
  - ACCESS → IDLE on `psel && penable && pready` (completion).
  - ACCESS → IDLE on `!psel` (abort; no write, no error).
- At the setup edge the block latches index, `pwrite`, `pstrb` and `pwdata`, and loads the wait counter with `WAIT_STATES`.
- ACCESS: the counter decrements once per access cycle while non-zero. `pready` goes high at the edge where the counter is, or becomes, zero.
- Read: `prdata` = memory[index], registered at the setup edge, held through ACCESS and cleared to 0 on return to IDLE. `pstrb` is ignored.
- Write: at the completion edge, each byte lane i with `pstrb[i]`=1 takes `pwdata` lane i; other lanes are unchanged. `pstrb` = 0 completes normally with no update.
- Out of range: `pslverr` = 1 alongside `pready`. No memory update; `prdata` = 0.
- In range: `pslverr` = 0.
- Attributes are sampled in setup only. Changes during ACCESS are ignored, which is protocol-illegal anyway.

## Timing
- Reset values: `prdata`=0, `pready`=0, `pslverr`=0, FSM=IDLE, counter=0, every memory word=0.
- Reset asserted mid-transfer aborts the transfer immediately. A pending write is discarded.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `WAIT_STATES`=0: setup at cycle T, `pready`=1 in cycle T+1, transfer completes at the end of T+1. This is the APB minimum of 2 cycles.
- `WAIT_STATES`=N: `pready` low for N access cycles, high on access cycle N+1. Total transfer is N+2 cycles.
- `pready` and `pslverr` fall at the completion edge. They are low in IDLE and during the setup cycle.
- Back-to-back: a setup in the cycle immediately after completion is accepted. Throughput is one transfer per N+2 cycles.
- Read-after-write to the same word in the next transfer returns the new data, because the write commits before the next setup edge.

## Structure
- Package `peripheral_apb4_memory_pkg` holds:
  - the FSM state enum typedef (IDLE, ACCESS);
  - the wait-counter width constant (4);
  - a function for the address-to-index shift amount.
- Sub-module `peripheral_apb4_memory_ram`: a `DEPTH` x `DATA_WIDTH` flop array with a per-byte-lane write enable, an asynchronous read port and an async-reset clear.
- The top level contains the FSM, wait counter, range check and output registers.

## Test plan
- Reset then idle: all outputs 0; a read of index 0 returns 0x00000000 with `pslverr`=0.
- `WAIT_STATES`=0: write 0xDEADBEEF to address 0x0010 with `pstrb`=4'b1111, then read 0x0010 → 0xDEADBEEF. Each transfer is 2 cycles and `pready` is high exactly 1 cycle.
- Byte strobes: write 0x11223344 to 0x0020 with `pstrb`=4'b0101 over memory holding 0xAAAAAAAA → read returns 0xAA22AA44.
- `WAIT_STATES`=3: `pready` is low for 3 access cycles, then high 1 cycle, for both read and write.
- Out of range with `DEPTH`=256: write to 0x0400 → `pslverr`=1 with `pready`; index 0 is unchanged. A read of 0x0400 → `prdata`=0, `pslverr`=1.
- Abort and reset: drop `psel` mid-ACCESS during a write → no update. Assert `presetn` low mid-write → all outputs 0 and memory cleared; the next transfer works normally.
